// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the sprite scanline scheduler slice.
package sprite_pkg;

  localparam int SPRITE_ROWS_W = 4;
  localparam logic [8:0] DEFAULT_LOAD_HPOS = 9'd256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sprite_vmatch.sv
// Vertical match for one sprite slot: is vpos inside the sprite's rows, and which row.
module sprite_vmatch
  import sprite_pkg::*;
#(
  parameter int SPRITE_HEIGHT = 16
) (
  input  logic [8:0]               vpos,
  input  logic [7:0]               y,
  input  logic                     en,
  output logic                     hit,
  output logic [SPRITE_ROWS_W-1:0] yofs
);

  logic [8:0] diff_s;

  // Rows above the sprite top wrap to large values and therefore miss.
  assign diff_s = vpos - {1'b0, y};
  assign hit    = en && (diff_s < 9'(SPRITE_HEIGHT));
  assign yofs   = diff_s[SPRITE_ROWS_W-1:0];

endmodule

// File: rtl/sprite_scanline_scheduler.sv
// Walks all sprite slots once per scanline in hblank and hands the shared bitmap
// ROM to each visible sprite in turn, one registered address/load strobe per cycle.
module sprite_scanline_scheduler
  import sprite_pkg::*;
#(
  parameter int         NUM_SPRITES   = 4,
  parameter int         SPRITE_HEIGHT = 16,
  parameter int         MAX_PER_LINE  = 3,
  parameter logic [8:0] LOAD_HPOS     = DEFAULT_LOAD_HPOS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               hpos,
  input  logic [8:0]               vpos,
  input  logic [8*NUM_SPRITES-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]   sprite_en,
  output logic [SPRITE_ROWS_W-1:0] rom_addr,
  output logic [NUM_SPRITES-1:0]   load,
  output logic [NUM_SPRITES-1:0]   line_active,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CNT_W = 4;

  sched_state_e             state_r, state_next_s;
  logic [IDX_W-1:0]         idx_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [SPRITE_ROWS_W-1:0] rom_addr_r;
  logic [NUM_SPRITES-1:0]   load_r, line_active_r, onehot_s;
  logic                     overflow_r, busy_s;
  logic                     trigger_s, last_s, hit_s, grant_s, deny_s;
  logic [SPRITE_ROWS_W-1:0] yofs_s;
  logic [7:0]               y_arr_s [NUM_SPRITES];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ysplit
    assign y_arr_s[g] = sprite_y[8*g +: 8];
  end

  sprite_vmatch #(
    .SPRITE_HEIGHT(SPRITE_HEIGHT)
  ) u_vmatch (
    .vpos (vpos),
    .y    (y_arr_s[idx_r]),
    .en   (sprite_en[idx_r]),
    .hit  (hit_s),
    .yofs (yofs_s)
  );

  assign trigger_s = (hpos == LOAD_HPOS);
  assign last_s    = (idx_r == IDX_W'(NUM_SPRITES - 1));
  assign grant_s   = (state_r == ST_SCAN) && hit_s && (cnt_r < CNT_W'(MAX_PER_LINE));
  assign deny_s    = (state_r == ST_SCAN) && hit_s && (cnt_r >= CNT_W'(MAX_PER_LINE));

  // One-hot strobe for the slot under evaluation.
  always_comb begin
    onehot_s        = {NUM_SPRITES{1'b0}};
    onehot_s[idx_r] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a trigger in any state (re)starts the scan.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: state_next_s = trigger_s ? ST_SCAN : ST_IDLE;
      ST_SCAN: begin
        if (trigger_s) begin
          state_next_s = ST_SCAN;
        end else if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_DONE: state_next_s = trigger_s ? ST_SCAN : ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_SCAN: busy_s = 1'b1;
      ST_DONE: busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Slot walk, hit counting and registered ROM address/strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r         <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      rom_addr_r    <= {SPRITE_ROWS_W{1'b0}};
      load_r        <= {NUM_SPRITES{1'b0}};
      line_active_r <= {NUM_SPRITES{1'b0}};
      overflow_r    <= 1'b0;
    end else if (trigger_s) begin
      idx_r         <= {IDX_W{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      load_r        <= {NUM_SPRITES{1'b0}};
      line_active_r <= {NUM_SPRITES{1'b0}};
      overflow_r    <= 1'b0;
    end else if (state_r == ST_SCAN) begin
      idx_r <= last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      if (grant_s) begin
        rom_addr_r    <= yofs_s;
        load_r        <= onehot_s;
        line_active_r <= line_active_r | onehot_s;
        cnt_r         <= cnt_r + CNT_W'(1);
      end else begin
        load_r <= {NUM_SPRITES{1'b0}};
      end
      if (deny_s) begin
        overflow_r <= 1'b1;
      end
    end else begin
      load_r <= {NUM_SPRITES{1'b0}};
    end
  end

  assign rom_addr    = rom_addr_r;
  assign load        = load_r;
  assign line_active = line_active_r;
  assign overflow    = overflow_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_sprite_scanline_scheduler.sv
// Directed bench: drives hpos 250..268 around the hblank trigger for chosen vpos
// values and checks strobes, addresses and flags against hand-computed values.
module tb_sprite_scanline_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos, vpos;
  logic [31:0] sprite_y;
  logic [3:0]  sprite_en;
  logic [3:0]  rom_addr, load, line_active;
  logic        busy, overflow;

  int checks = 0;
  int failures = 0;

  logic [3:0] load_log [0:18];
  logic [3:0] addr_log [0:18];
  logic       busy_log [0:18];
  logic [3:0] la_end;
  logic       ov_end;

  always #5 clk = ~clk;

  sprite_scanline_scheduler #(
    .NUM_SPRITES(4), .SPRITE_HEIGHT(16), .MAX_PER_LINE(3), .LOAD_HPOS(9'd256)
  ) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .sprite_y(sprite_y), .sprite_en(sprite_en),
    .rom_addr(rom_addr), .load(load), .line_active(line_active),
    .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One hblank window, hpos 250..268; reset is pulsed during the cycle hpos==rst_at.
  task automatic run_line(input logic [8:0] v, input logic [8:0] rst_at);
    vpos = v;
    for (int h = 250; h <= 268; h++) begin
      @(posedge clk);
      #1;
      hpos  = 9'(h);
      reset = (9'(h) == rst_at);
      #1;
      load_log[h-250] = load;
      addr_log[h-250] = rom_addr;
      busy_log[h-250] = busy;
    end
    la_end = line_active;
    ov_end = overflow;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hpos  = 9'd0;
  endtask

  function automatic logic [3:0] loads_except(input int skip);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i <= 18; i++) begin
      if (i != skip) acc = acc | load_log[i];
    end
    return acc;
  endfunction

  initial begin
    reset     = 1'b1;
    hpos      = 9'd0;
    vpos      = 9'd0;
    sprite_y  = 32'd0;
    sprite_en = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_line_active", 32'(line_active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Single sprite in slot 2
    sprite_y  = {8'd0, 8'd100, 8'd0, 8'd0};
    sprite_en = 4'b0100;
    run_line(9'd105, 9'd0);
    chk("single_load", 32'(load_log[10]), 32'h4);
    chk("single_addr", 32'(addr_log[10]), 32'd5);
    chk("single_other_loads", 32'(loads_except(10)), 32'd0);
    chk("single_line_active", 32'(la_end), 32'h4);
    chk("busy_257", 32'(busy_log[7]), 32'd1);
    chk("busy_261", 32'(busy_log[11]), 32'd1);
    chk("busy_262", 32'(busy_log[12]), 32'd0);
    chk("busy_256", 32'(busy_log[6]), 32'd0);

    // Edge rows, slot 0 at y=100
    sprite_y  = {8'd0, 8'd0, 8'd0, 8'd100};
    sprite_en = 4'b0001;
    run_line(9'd99, 9'd0);
    chk("edge99_none", 32'(loads_except(-1)), 32'd0);
    run_line(9'd100, 9'd0);
    chk("edge100_load", 32'(load_log[8]), 32'h1);
    chk("edge100_addr", 32'(addr_log[8]), 32'd0);
    run_line(9'd115, 9'd0);
    chk("edge115_load", 32'(load_log[8]), 32'h1);
    chk("edge115_addr", 32'(addr_log[8]), 32'd15);
    run_line(9'd116, 9'd0);
    chk("edge116_none", 32'(loads_except(-1)), 32'd0);
    chk("edge116_line_active", 32'(la_end), 32'd0);

    // Wrap, slot 1 at y=255
    sprite_y  = {8'd0, 8'd0, 8'd255, 8'd0};
    sprite_en = 4'b0010;
    run_line(9'd262, 9'd0);
    chk("wrap_load", 32'(load_log[9]), 32'h2);
    chk("wrap_addr", 32'(addr_log[9]), 32'd7);
    run_line(9'd10, 9'd0);
    chk("wrap_low_none", 32'(loads_except(-1)), 32'd0);

    // Overflow, all four slots at y=50
    sprite_y  = {8'd50, 8'd50, 8'd50, 8'd50};
    sprite_en = 4'b1111;
    run_line(9'd52, 9'd0);
    chk("ovf_load258", 32'(load_log[8]), 32'h1);
    chk("ovf_load259", 32'(load_log[9]), 32'h2);
    chk("ovf_load260", 32'(load_log[10]), 32'h4);
    chk("ovf_load261", 32'(load_log[11]), 32'h0);
    chk("ovf_addr261", 32'(addr_log[11]), 32'd2);
    chk("ovf_flag", 32'(ov_end), 32'd1);
    chk("ovf_line_active", 32'(la_end), 32'h7);
    sprite_en = 4'b0111;
    run_line(9'd52, 9'd0);
    chk("ovf_clear", 32'(ov_end), 32'd0);
    chk("ovf_clear_line_active", 32'(la_end), 32'h7);

    // Disabled slot with matching row
    sprite_y  = {8'd0, 8'd0, 8'd0, 8'd100};
    sprite_en = 4'b0000;
    run_line(9'd100, 9'd0);
    chk("disable_none", 32'(loads_except(-1)), 32'd0);
    chk("disable_line_active", 32'(la_end), 32'd0);

    // Reset mid-scan at hpos 258, then a normal line
    sprite_y  = {8'd50, 8'd50, 8'd50, 8'd50};
    sprite_en = 4'b1111;
    run_line(9'd52, 9'd258);
    chk("mid_rst_load259", 32'(load_log[9]), 32'd0);
    chk("mid_rst_busy259", 32'(busy_log[9]), 32'd0);
    chk("mid_rst_no_strobes", 32'(loads_except(8)), 32'd0);
    run_line(9'd52, 9'd0);
    chk("after_rst_load258", 32'(load_log[8]), 32'h1);
    chk("after_rst_load260", 32'(load_log[10]), 32'h4);
    chk("after_rst_line_active", 32'(la_end), 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
